// File: rtl/pool_controller.sv
// Walks an N x N feature map in 2x2 windows, feeds a pooling unit and
// writes one pooled pixel per window to an (N/2) x (N/2) output map.
module pool_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        cfg_size,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] win00,
    output logic [DATA_W-1:0] win01,
    output logic [DATA_W-1:0] win10,
    output logic [DATA_W-1:0] win11,
    output logic              pool_start,
    input  logic [DATA_W-1:0] pool_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] RD0  = 4'd1;
    localparam logic [3:0] RD1  = 4'd2;
    localparam logic [3:0] RD2  = 4'd3;
    localparam logic [3:0] RD3  = 4'd4;
    localparam logic [3:0] CAP  = 4'd5;
    localparam logic [3:0] POOL = 4'd6;
    localparam logic [3:0] WR   = 4'd7;
    localparam logic [3:0] DONE = 4'd8;

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [DATA_W-1:0] res;
    logic              cfg_ok;
    logic              accept;
    logic              last_i;
    logic              last_j;
    logic              row_hi;
    logic              col_hi;

    assign cfg_ok = !cfg_size[0] && (cfg_size >= 6'd2) && (cfg_size <= 6'd32);
    assign accept = (state == IDLE) && start && cfg_ok;

    assign half   = n >> 1;
    assign last_i = (i == half - ADDR_W'(1));
    assign last_j = (j == half - ADDR_W'(1));

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign rd_en      = (state == RD0) || (state == RD1) ||
                        (state == RD2) || (state == RD3);
    assign pool_start = (state == POOL);
    assign wr_en      = (state == WR);

    // Bottom row is fetched by RD2/RD3, right column by RD1/RD3.
    assign row_hi = (state == RD2) || (state == RD3);
    assign col_hi = (state == RD1) || (state == RD3);
    assign row    = (i << 1) + ADDR_W'(row_hi);
    assign col    = (j << 1) + ADDR_W'(col_hi);

    assign rd_addr = rd_en ? (row * n + col) : '0;
    assign wr_addr = wr_en ? (i * half + j) : '0;
    assign wr_data = res;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RD0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = RD3;
            RD3:     state_nxt = CAP;
            CAP:     state_nxt = POOL;
            POOL:    state_nxt = WR;
            WR:      state_nxt = (last_i && last_j) ? DONE : RD0;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n       <= '0;
            i       <= '0;
            j       <= '0;
            win00   <= '0;
            win01   <= '0;
            win10   <= '0;
            win11   <= '0;
            res     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= (state == IDLE) && start && !cfg_ok;
            // Read data lags the address by one cycle.
            case (state)
                IDLE: begin
                    if (accept) begin
                        n <= ADDR_W'(cfg_size);
                        i <= '0;
                        j <= '0;
                    end
                end
                RD1:  win00 <= rd_data;
                RD2:  win01 <= rd_data;
                RD3:  win10 <= rd_data;
                CAP:  win11 <= rd_data;
                POOL: res   <= pool_result;
                WR: begin
                    if (!last_j) begin
                        j <= j + ADDR_W'(1);
                    end else begin
                        j <= '0;
                        i <= i + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_controller.sv
// Directed bench for pool_controller with a memory model and a
// sum>>2 pooling model.
module tb_pool_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  cfg_size;
    logic        busy, done, cfg_err, rd_en, pool_start, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [15:0] rd_data;
    logic [15:0] win00, win01, win10, win11;
    logic [15:0] pool_result, wr_data;
    logic [17:0] win_sum;

    logic [15:0] mem [0:1023];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int rd_log[$];
    int wa_log[$];
    int wd_log[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int ps_cnt = 0;

    pool_controller #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_size(cfg_size),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win00(win00), .win01(win01), .win10(win10), .win11(win11),
        .pool_start(pool_start), .pool_result(pool_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    assign win_sum = win00 + win01 + win10 + win11;
    assign pool_result = win_sum[17:2];

    always @(negedge clk) begin
        if (rd_en) rd_log.push_back(int'(rd_addr));
        if (wr_en) begin
            wa_log.push_back(int'(wr_addr));
            wd_log.push_back(int'(wr_data));
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (cfg_err) err_cnt <= err_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (pool_start) ps_cnt <= ps_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int n, output int s);
        @(posedge clk);
        #1;
        cfg_size = 6'(n);
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base, output int dc);
        int k;
        k = 0;
        while (done_cnt == base && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == base) begin
            check("done timeout", 0, 1);
            dc = -1;
        end else begin
            dc = done_cyc;
        end
    endtask

    task automatic fill_addr();
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
    endtask

    task automatic run_n2(input string tag);
        int s, dc, rb, wb, db, pb;
        mem[0] = 16'd4; mem[1] = 16'd8; mem[2] = 16'd12; mem[3] = 16'd16;
        rb = rd_log.size(); wb = wa_log.size();
        db = done_cnt; pb = ps_cnt;
        pulse_start(2, s);
        wait_done(50, db, dc);
        @(posedge clk);
        check({tag, " done time"}, dc - s, 8);
        check({tag, " rd count"}, rd_log.size() - rb, 4);
        for (int k = 0; k < 4; k++) check({tag, " rd addr"}, rd_log[rb + k], k);
        check({tag, " wr count"}, wa_log.size() - wb, 1);
        check({tag, " wr addr"}, wa_log[wb], 0);
        check({tag, " wr data"}, wd_log[wb], 10);
        check({tag, " pool pulses"}, ps_cnt - pb, 1);
    endtask

    initial begin
        int s, dc, rb, wb, db, eb, bb, bad_a, bad_d;
        int exp_d[4];
        int exp_r[4];
        rst = 1'b1;
        start = 1'b0;
        cfg_size = '0;
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst cfg_err", int'(cfg_err), 0);
        check("rst rd_en", int'(rd_en), 0);
        check("rst wr_en", int'(wr_en), 0);
        check("rst pool_start", int'(pool_start), 0);
        check("rst rd_addr", int'(rd_addr), 0);
        check("rst wr_data", int'(wr_data), 0);

        run_n2("n2");

        // N=4 with an ignored start re-pulse mid-run.
        fill_addr();
        exp_d = '{2, 4, 10, 12};
        exp_r = '{10, 11, 14, 15};
        rb = rd_log.size(); wb = wa_log.size(); db = done_cnt;
        pulse_start(4, s);
        repeat (5) @(posedge clk);
        #1;
        cfg_size = 6'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, db, dc);
        @(posedge clk);
        check("n4 done time", dc - s, 29);
        check("n4 wr count", wa_log.size() - wb, 4);
        for (int k = 0; k < 4; k++) begin
            check("n4 wr addr", wa_log[wb + k], k);
            check("n4 wr data", wd_log[wb + k], exp_d[k]);
            check("n4 rd win11", rd_log[rb + 12 + k], exp_r[k]);
        end
        check("n4 done pulses", done_cnt - db, 1);

        // Illegal sizes.
        for (int t = 0; t < 3; t++) begin
            int sz;
            sz = (t == 0) ? 3 : (t == 1) ? 0 : 34;
            eb = err_cnt; bb = busy_cnt; rb = rd_log.size();
            pulse_start(sz, s);
            repeat (3) @(posedge clk);
            check("cfg_err pulse", err_cnt - eb, 1);
            check("cfg_err busy", busy_cnt - bb, 0);
            check("cfg_err rd", rd_log.size() - rb, 0);
        end

        // Reset wins over a simultaneous start.
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        cfg_size = 6'd4;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst prio busy", int'(busy), 0);

        // Reset during RD2 of window 1.
        rb = rd_log.size(); wb = wa_log.size();
        pulse_start(4, s);
        repeat (9) @(posedge clk);
        #1;
        check("abort rd_addr", int'(rd_addr), 6);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort rd_en", int'(rd_en), 0);
        check("abort rd_addr0", int'(rd_addr), 0);
        check("abort win00", int'(win00), 0);
        check("abort wr_data", int'(wr_data), 0);
        rb = rd_log.size();
        repeat (20) @(posedge clk);
        check("abort wr count", wa_log.size() - wb, 1);
        check("abort no rd", rd_log.size() - rb, 0);
        #1;
        rst = 1'b0;
        run_n2("restart n2");

        // Full 32x32 map.
        fill_addr();
        rb = rd_log.size(); wb = wa_log.size(); db = done_cnt;
        pulse_start(32, s);
        wait_done(2000, db, dc);
        @(posedge clk);
        check("n32 done time", dc - s, 1793);
        check("n32 wr count", wa_log.size() - wb, 256);
        check("n32 rd count", rd_log.size() - rb, 1024);
        check("n32 last rd", rd_log[rd_log.size() - 1], 1023);
        bad_a = 0;
        bad_d = 0;
        for (int k = 0; k < 256 && wb + k < wa_log.size(); k++) begin
            if (wa_log[wb + k] != k) bad_a++;
            if (wd_log[wb + k] != (k / 16) * 64 + (k % 16) * 2 + 16) bad_d++;
        end
        check("n32 wr addr errs", bad_a, 0);
        check("n32 wr data errs", bad_d, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool_controller.md
POOL_CONTROLLER -- requirements
Module: pool_controller

Interface
REQ-001 Parameter DATA_W, default 16: pixel width, matches the 2x2 pooling unit's pixel width.
REQ-002 Parameter ADDR_W, default 10: feature-map memory address width (maximum 32x32 map).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle request to pool the whole map.
REQ-006 Port cfg_size, input, 6: input map side N, sampled only when start is accepted.
REQ-007 Port busy, output, 1: high from the cycle after acceptance until done.
REQ-008 Port done, output, 1: one-cycle pulse on completion.
REQ-009 Port cfg_err, output, 1: one-cycle pulse when start is rejected for an illegal N.
REQ-010 Port rd_en / rd_addr, output, 1 / ADDR_W: input-map read request; data returns one cycle later.
REQ-011 Port rd_data, input, DATA_W: read data, valid the cycle after rd_en.
REQ-012 Port win00, win01, win10, win11, output, DATA_W each: registered window pixels (r,c), (r,c+1), (r+1,c), (r+1,c+1).
REQ-013 Port pool_start, output, 1: enables the pooling unit for one cycle.
REQ-014 Port pool_result, input, DATA_W: combinational result from the pooling unit (sum>>2).
REQ-015 Port wr_en / wr_addr / wr_data, output, 1 / ADDR_W / DATA_W: output-map write port.

Function
REQ-016 States SHALL be IDLE, RD0, RD1, RD2, RD3, CAP, POOL, WR, DONE.
REQ-017 In IDLE, start with N even and 2<=N<=32 SHALL latch N, clear window indices i=j=0, and go to RD0 next cycle.
REQ-018 In IDLE, start with N odd, N<2 or N>32 SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-019 With r=2i and c=2j, rd_addr SHALL be r*N+c in RD0, r*N+c+1 in RD1, (r+1)*N+c in RD2, and (r+1)*N+c+1 in RD3, with rd_en=1 in those four states only.
REQ-020 rd_data SHALL be captured into win00 in RD1, win01 in RD2, win10 in RD3, and win11 in CAP.
REQ-021 In POOL, pool_start SHALL be 1 and pool_result SHALL be registered at the end of the cycle; pool_start SHALL be 0 in all other states.
REQ-022 In WR, wr_en SHALL be 1, wr_addr SHALL be i*(N/2)+j, and wr_data SHALL be the registered result.
REQ-023 After WR: if j<N/2-1 then j increments; else j=0 and i increments; if the last window was written, next state SHALL be DONE, else RD0.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Each window SHALL take exactly 7 cycles; done SHALL assert at cycle t0+1+7*(N/2)^2, where t0 is the start-acceptance cycle.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start asserted while busy SHALL be ignored, with no effect on N, indices or outputs.
REQ-028 Address arithmetic SHALL use ADDR_W bits without truncation for N<=32 (maximum address 1023).

Reset
REQ-029 rst SHALL force IDLE, i=j=0, and N=0.
REQ-030 rst SHALL force busy, done, cfg_err, rd_en, pool_start and wr_en to 0, and all address, window and data outputs to 0, on the next edge.
REQ-031 rst asserted mid-operation SHALL abort with no further rd_en or wr_en pulses; a new start after rst deasserts SHALL behave as from power-up.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification
REQ-033 N=2, map {4,8,12,16}, pool model sum>>2 -> reads at addresses 0,1,2,3; one write wr_addr=0, wr_data=10; done at t0+8.
REQ-034 N=4, map value = address -> writes (0,2),(1,4),(2,10),(3,12); reads for window (1,1) at 10,11,14,15; done at t0+29.
REQ-035 cfg_size=3, then separately 0 and 34 -> cfg_err pulse each time, busy stays 0, no rd_en.
REQ-036 start re-pulsed during the N=4 run with cfg_size=2 -> ignored; still exactly 4 writes; done at t0+29.
REQ-037 rst during RD2 of window 1 -> all outputs 0 next cycle, no further writes; a restart with N=2 then passes REQ-033.
REQ-038 N=32, map value = address -> 256 writes at addresses 0..255, last rd_addr 1023, done at t0+1793.
